// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encoding and sizing helpers shared by the serial subtractor.
package serial_subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int step_count(input int width, input int bpc);
        return width / ((bpc > 0) ? bpc : 1);
    endfunction

    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result buses.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit a - b - b_in cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic borrow_out
);
    assign diff       = a ^ b ^ b_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - b_in, BITS_PER_CYCLE bits per clock, LSB first.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int STEPS = step_count(WIDTH, BITS_PER_CYCLE);
    localparam int CW    = cnt_width(STEPS);

    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_params
        $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH, WIDTH >= 2");
    end

    state_t                    state;
    state_t                    state_next;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          res;
    logic [WIDTH-1:0]          res_next;
    logic [BITS_PER_CYCLE-1:0] slice_a;
    logic [BITS_PER_CYCLE-1:0] slice_b;
    logic [BITS_PER_CYCLE-1:0] slice_d;
    logic [BITS_PER_CYCLE:0]   chain;
    logic [CW-1:0]             cnt;
    logic                      bor;
    logic                      a_msb;
    logic                      b_msb;
    logic                      accept;
    logic                      last;

    assign slice_a  = a_sh[BITS_PER_CYCLE-1:0];
    assign slice_b  = b_sh[BITS_PER_CYCLE-1:0];
    assign chain[0] = bor;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        full_subtractor u_cell (
            .a         (slice_a[i]),
            .b         (slice_b[i]),
            .b_in      (chain[i]),
            .diff      (slice_d[i]),
            .borrow_out(chain[i+1])
        );
    end

    // Result fills from the MSB side so the first slice ends up at bit 0 after STEPS shifts.
    assign res_next = (res >> BITS_PER_CYCLE) | (WIDTH'(slice_d) << (WIDTH - BITS_PER_CYCLE));
    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign last     = (state == RUN) && (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = accept ? RUN : last ? DONE : (state == RUN) ? RUN : IDLE;
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
            bus.overflow   <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            bor   <= bus.b_in;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> BITS_PER_CYCLE;
            b_sh <= b_sh >> BITS_PER_CYCLE;
            res  <= res_next;
            bor  <= chain[BITS_PER_CYCLE];
            cnt  <= cnt + CW'(1);
            if (last) begin
                bus.diff       <= res_next;
                bus.borrow_out <= chain[BITS_PER_CYCLE];
                bus.overflow   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed, random and exhaustive checks of four serial_subtractor configurations.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) i81 ();
    serial_subtractor_if #(.WIDTH(8)) i84 ();
    serial_subtractor_if #(.WIDTH(3)) i31 ();
    serial_subtractor_if #(.WIDTH(3)) i33 ();

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u81 (.clk(clk), .rst(rst), .bus(i81));
    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u84 (.clk(clk), .rst(rst), .bus(i84));
    serial_subtractor #(.WIDTH(3), .BITS_PER_CYCLE(1)) u31 (.clk(clk), .rst(rst), .bus(i31));
    serial_subtractor #(.WIDTH(3), .BITS_PER_CYCLE(3)) u33 (.clk(clk), .rst(rst), .bus(i33));

    function automatic int wof(input int w);
        return (w < 2) ? 8 : 3;
    endfunction

    function automatic int steps(input int w);
        case (w)
            0:       return 8;
            1:       return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    // Reference: plain integer arithmetic, packed as {overflow, borrow, diff}.
    function automatic logic [9:0] model(input int wd, input int a, input int b, input int bin);
        int d   = a - b - bin;
        int df  = d & ((1 << wd) - 1);
        int am  = (a >> (wd - 1)) & 1;
        int bm  = (b >> (wd - 1)) & 1;
        int dm  = (df >> (wd - 1)) & 1;
        logic ovf = (am != bm) && (dm != am);
        logic bor = (d < 0);
        return {ovf, bor, df[7:0]};
    endfunction

    function automatic logic [9:0] sel_res(input int w);
        case (w)
            0:       return {i81.overflow, i81.borrow_out, i81.diff};
            1:       return {i84.overflow, i84.borrow_out, i84.diff};
            2:       return {i31.overflow, i31.borrow_out, 5'b0, i31.diff};
            default: return {i33.overflow, i33.borrow_out, 5'b0, i33.diff};
        endcase
    endfunction

    function automatic logic sel_done(input int w);
        case (w)
            0:       return i81.done;
            1:       return i84.done;
            2:       return i31.done;
            default: return i33.done;
        endcase
    endfunction

    function automatic logic sel_busy(input int w);
        case (w)
            0:       return i81.busy;
            1:       return i84.busy;
            2:       return i31.busy;
            default: return i33.busy;
        endcase
    endfunction

    task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
        case (w)
            0:       begin i81.a = a;      i81.b = b;      i81.b_in = bin; end
            1:       begin i84.a = a;      i84.b = b;      i84.b_in = bin; end
            2:       begin i31.a = a[2:0]; i31.b = b[2:0]; i31.b_in = bin; end
            default: begin i33.a = a[2:0]; i33.b = b[2:0]; i33.b_in = bin; end
        endcase
    endtask

    task automatic set_start(input int w, input logic s);
        case (w)
            0:       i81.start = s;
            1:       i84.start = s;
            2:       i31.start = s;
            default: i33.start = s;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge right after the accepting edge.
    task automatic start_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
        drive(w, a, b, bin);
        set_start(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(w, 1'b0);
    endtask

    // Counts cycles until done and the busy cycles before it; poke >= 0 injects a start mid-run.
    task automatic wait_done(input int w, input string tag, input int poke);
        int j  = 0;
        int nb = 0;
        while (!sel_done(w) && j < 40) begin
            nb += int'(sel_busy(w));
            if (poke >= 0 && j == poke) begin
                drive(w, 8'hEE, 8'h11, 1'b1);
                set_start(w, 1'b1);
            end
            if (poke >= 0 && j == poke + 1) set_start(w, 1'b0);
            @(negedge clk);
            j++;
        end
        chk({tag, " latency"}, j, steps(w));
        chk({tag, " busy"}, nb, steps(w));
    endtask

    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input string tag, input int poke);
        start_op(w, a, b, bin);
        wait_done(w, tag, poke);
        chk({tag, " result"}, sel_res(w), model(wof(w), a, b, bin));
        @(negedge clk);
        chk({tag, " pulse"}, sel_done(w), 0);
    endtask

    initial begin
        int nd;
        logic [7:0] ra;
        logic [7:0] rb;
        for (int w = 0; w < 4; w++) begin
            drive(w, 8'($urandom), 8'($urandom), 1'($urandom));
            set_start(w, 1'($urandom));
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 4; w++) begin
            set_start(w, 1'b0);
            chk($sformatf("reset res w%0d", w), sel_res(w), 0);
            chk($sformatf("reset busy w%0d", w), sel_busy(w), 0);
            chk($sformatf("reset done w%0d", w), sel_done(w), 0);
        end
        repeat (3) @(negedge clk);
        for (int w = 0; w < 4; w++) chk($sformatf("idle busy w%0d", w), sel_busy(w), 0);

        run_op(0, 8'h00, 8'h01, 1'b0, "w8b1 00-01", -1);
        chk("w8b1 00-01 const", sel_res(0), {1'b0, 1'b1, 8'hFF});
        run_op(0, 8'h80, 8'h01, 1'b0, "w8b1 80-01", -1);
        chk("w8b1 80-01 const", sel_res(0), {1'b1, 1'b0, 8'h7F});
        run_op(0, 8'h05, 8'h05, 1'b1, "w8b1 05-05-1", -1);
        chk("w8b1 05-05-1 const", sel_res(0), {1'b0, 1'b1, 8'hFF});

        start_op(1, 8'h3C, 8'hA5, 1'b0);
        wait_done(1, "w8b4 3C-A5", -1);
        chk("w8b4 3C-A5 const", sel_res(1), {1'b1, 1'b1, 8'h97});
        start_op(1, 8'h10, 8'h01, 1'b0);
        chk("w8b4 held", sel_res(1), {1'b1, 1'b1, 8'h97});
        wait_done(1, "w8b4 b2b", -1);
        chk("w8b4 b2b const", sel_res(1), {1'b0, 1'b0, 8'h0F});
        @(negedge clk);
        chk("w8b4 b2b pulse", sel_done(1), 0);

        run_op(0, 8'h12, 8'h34, 1'b0, "w8b1 ignore", 3);
        chk("w8b1 ignore const", sel_res(0), {1'b0, 1'b1, 8'hDE});

        start_op(0, 8'hF0, 8'h0F, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort res", sel_res(0), 0);
        chk("abort busy", sel_busy(0), 0);
        chk("abort done", sel_done(0), 0);
        nd = 0;
        repeat (12) begin
            nd += int'(sel_done(0));
            @(negedge clk);
        end
        chk("abort no done", nd, 0);
        run_op(0, 8'h20, 8'h10, 1'b0, "w8b1 20-10", -1);
        chk("w8b1 20-10 const", sel_res(0), {1'b0, 1'b0, 8'h10});

        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(k % 2, ra, rb, 1'($urandom), $sformatf("rand%0d", k), -1);
        end

        for (int w = 2; w < 4; w++)
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++)
                    for (int c = 0; c < 2; c++)
                        run_op(w, 8'(a), 8'(b), 1'(c), $sformatf("ex w%0d %0d-%0d-%0d", w, a, b, c), -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor that computes diff = a - b - b_in over WIDTH bits. It processes BITS_PER_CYCLE bits per clock, LSB first, through a ripple chain of full-subtractor cells and a registered borrow. A start/busy/done handshake controls each operation. It reports the unsigned borrow_out and a signed overflow flag. The block is the sequential, width-generalised successor to the single-bit full subtractor cell, for datapaths that trade latency for area.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly (elaboration-time check)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when block is idle or done
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
b_in  input  1  borrow-in, captured on accepted start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse; results valid from this cycle
diff  output  WIDTH  difference, held until next accepted start
borrow_out  output  1  final unsigned borrow, held with diff
overflow  output  1  signed (two's complement) overflow, held with diff

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: busy=0, done=0, diff=0, borrow_out=0, overflow=0. State resets to IDLE and the step counter to 0.
- Constant STEPS = WIDTH/BITS_PER_CYCLE. The counter is $clog2(STEPS) bits wide, with a minimum of 1 bit.
- States:
  - IDLE: waiting for start.
  - RUN: busy=1; processing one slice per cycle.
  - DONE: done=1 for exactly one cycle.
- IDLE or DONE with start=1:
  - Capture a and b into shift registers and b_in into the borrow register.
  - Save the operand MSBs a[WIDTH-1] and b[WIDTH-1].
  - Clear the counter and go to RUN.
  - diff, borrow_out and overflow keep their old values until the new DONE.
- DONE with start=0: go to IDLE. Outputs are held.
- RUN, each cycle:
  - Feed the low BITS_PER_CYCLE bits of the a/b shift registers, plus the borrow register, into the cell chain.
  - Shift the slice difference into the result register from the MSB side.
  - Shift the operands right by BITS_PER_CYCLE.
  - Load the borrow register with the chain's borrow_out.
  - Increment the counter.
  - When the counter equals STEPS-1 this cycle, the next state is DONE.
- DONE entry, registered on the same edge as the last RUN slice:
  - diff = result register.
  - borrow_out = borrow register.
  - overflow = (saved a MSB != saved b MSB) AND (diff[WIDTH-1] != saved a MSB).
- Latency: start sampled at edge k; done is high in the cycle after edge k+STEPS. For WIDTH=8, BITS_PER_CYCLE=1 that is 8 RUN cycles plus the DONE cycle.
- start during RUN is ignored: no restart and no queueing.
- Back-to-back: start during the DONE cycle is accepted, so the next operation begins without an IDLE cycle.
- Reset mid-RUN aborts the operation and all outputs return to reset values. No done pulse is produced for the aborted operation.
- a, b and b_in are don't-care except on an accepted start.
- Arithmetic is modulo 2^WIDTH. borrow_out=1 iff a < b + b_in, compared unsigned.

Decomposition:
- Shared package: state encoding (IDLE, RUN, DONE as a 2-bit localparam set) and a step-count helper function.
- Sub-module: reuse the existing full_subtractor cell (a, b, b_in -> diff, borrow_out). Instantiate BITS_PER_CYCLE copies in a generate ripple chain; no new cell is needed.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> busy=0, done=0, diff=0, borrow_out=0, overflow=0; start held low leaves the block in IDLE.
- W=8, BPC=1: a=8'h00, b=8'h01, b_in=0, start 1 cycle -> busy for 8 cycles; done pulse 9 cycles after start; diff=8'hFF, borrow_out=1, overflow=0.
- W=8, BPC=1: a=8'h80, b=8'h01, b_in=0 -> diff=8'h7F, borrow_out=0, overflow=1. Then a=8'h05, b=8'h05, b_in=1 -> diff=8'hFF, borrow_out=1, overflow=0.
- W=8, BPC=4: a=8'h3C, b=8'hA5, b_in=0 -> done 3 cycles after start; diff=8'h97, borrow_out=1, overflow=1. Second start in the DONE cycle with a=8'h10, b=8'h01 -> diff=8'h0F, borrow_out=0 after a further 3 cycles.
- Control robustness:
  - start pulsed during RUN with different operands -> ignored; the original result is delivered.
  - rst asserted mid-RUN -> outputs zero, no done pulse.
  - A following operation a=8'h20, b=8'h10 -> diff=8'h10.
- Exhaustive check at W=3 for BPC=1 and BPC=3: all 128 (a, b, b_in) combinations compared against a reference model -> diff, borrow_out and overflow match on every done pulse, and exactly one done pulse per start.
